sysahb_master_arbiter: RTL and testbench

- Two-master arbiter and address/data multiplexer in front of the system AHB-Lite fabric (decoder, slave mux, block RAM, default slave).
- Shares the single sysahb port between M0 (CPU instruction/data master) and M1 (debug loader / DMA master).
- Ownership changes only on transfer boundaries. An optional hold limit gives round-robin fairness under contention.

---
 rtl/sysahb_master_arbiter.sv | 128 ++++++++++++
 tb/tb_sysahb_master_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysahb_master_arbiter.sv
// ============================================================================
// Module   : sysahb_master_arbiter
// Purpose  : Two-master AHB-Lite arbiter and address/data mux for the sysahb fabric.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysahb_master_arbiter #(
  parameter int PARK_MASTER = 0,
  parameter int MAX_HOLD    = 16,
  parameter int CNT_W       = 5
) (
  input  logic        sys_clk,
  input  logic        sys_resetn,

  input  logic        m0_hbusreq,
  output logic        m0_hgrant,
  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [2:0]  m0_hburst,
  input  logic [3:0]  m0_hprot,
  input  logic [31:0] m0_hwdata,
  output logic        m0_hready,
  output logic        m0_hresp,
  output logic [31:0] m0_hrdata,

  input  logic        m1_hbusreq,
  output logic        m1_hgrant,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [2:0]  m1_hburst,
  input  logic [3:0]  m1_hprot,
  input  logic [31:0] m1_hwdata,
  output logic        m1_hready,
  output logic        m1_hresp,
  output logic [31:0] m1_hrdata,

  output logic [31:0] sysahb_haddr,
  output logic [1:0]  sysahb_htrans,
  output logic        sysahb_hwrite,
  output logic [2:0]  sysahb_hsize,
  output logic [2:0]  sysahb_hburst,
  output logic [3:0]  sysahb_hprot,
  output logic [31:0] sysahb_hwdata,
  input  logic        sysahb_hready,
  input  logic        sysahb_hresp,
  input  logic [31:0] sysahb_hrdata
);

  localparam logic             PARK      = 1'(PARK_MASTER);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(MAX_HOLD);
  localparam logic [1:0]       HT_IDLE   = 2'b00;
  localparam logic [1:0]       HT_NONSEQ = 2'b10;

  logic             grant_q;
  logic             downer_q;
  logic [CNT_W-1:0] hold_cnt;
  logic             grant_d;
  logic [CNT_W-1:0] hold_d;

  logic [1:0] owner_htrans;
  logic       owner_req;
  logic       other_req;
  logic       boundary;
  logic       hold_hit;

  assign owner_htrans = grant_q ? m1_htrans  : m0_htrans;
  assign owner_req    = grant_q ? m1_hbusreq : m0_hbusreq;
  assign other_req    = grant_q ? m0_hbusreq : m1_hbusreq;
  // SEQ and BUSY are never boundaries, so bursts in flight are never split.
  assign boundary     = (owner_htrans == HT_IDLE) || (owner_htrans == HT_NONSEQ);
  assign hold_hit     = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM);

  always_comb begin
    grant_d = grant_q;
    hold_d  = hold_cnt;
    if (owner_htrans[1] && (hold_cnt != {CNT_W{1'b1}})) begin
      hold_d = hold_cnt + 1'b1;
    end
    if (boundary) begin
      if (other_req && (!owner_req || hold_hit)) begin
        grant_d = ~grant_q;
        hold_d  = '0;
      end else if (!other_req && !owner_req && (grant_q != PARK)) begin
        grant_d = PARK;
        hold_d  = '0;
      end
    end
  end

  // A stalled fabric freezes every register, including the data-phase owner.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      grant_q  <= PARK;
      downer_q <= PARK;
      hold_cnt <= '0;
    end else if (sysahb_hready) begin
      grant_q  <= grant_d;
      downer_q <= grant_q;
      hold_cnt <= hold_d;
    end
  end

  assign m0_hgrant = ~grant_q;
  assign m1_hgrant = grant_q;

  assign sysahb_haddr  = grant_q ? m1_haddr  : m0_haddr;
  assign sysahb_htrans = sys_resetn ? owner_htrans : HT_IDLE;
  assign sysahb_hwrite = grant_q ? m1_hwrite : m0_hwrite;
  assign sysahb_hsize  = grant_q ? m1_hsize  : m0_hsize;
  assign sysahb_hburst = grant_q ? m1_hburst : m0_hburst;
  assign sysahb_hprot  = grant_q ? m1_hprot  : m0_hprot;
  assign sysahb_hwdata = downer_q ? m1_hwdata : m0_hwdata;

  assign m0_hready = sysahb_hready;
  assign m1_hready = sysahb_hready;
  assign m0_hrdata = sysahb_hrdata;
  assign m1_hrdata = sysahb_hrdata;
  assign m0_hresp  = sysahb_hresp & ~downer_q;
  assign m1_hresp  = sysahb_hresp &  downer_q;

endmodule

`default_nettype wire

// File: tb/tb_sysahb_master_arbiter.sv
// ============================================================================
// Module   : tb_sysahb_master_arbiter
// Purpose  : Directed self-checking bench for sysahb_master_arbiter (MAX_HOLD = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sysahb_master_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_resetn;
  logic        m0_hbusreq, m1_hbusreq;
  logic        m0_hgrant, m1_hgrant;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [2:0]  m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready;
  logic        m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [31:0] sysahb_haddr;
  logic [1:0]  sysahb_htrans;
  logic        sysahb_hwrite;
  logic [2:0]  sysahb_hsize;
  logic [2:0]  sysahb_hburst;
  logic [3:0]  sysahb_hprot;
  logic [31:0] sysahb_hwdata;
  logic        sysahb_hready;
  logic        sysahb_hresp;
  logic [31:0] sysahb_hrdata;

  int n_assert = 0;
  int n_fail   = 0;

  sysahb_master_arbiter #(
    .PARK_MASTER (0),
    .MAX_HOLD    (4),
    .CNT_W       (5)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_resetn    (sys_resetn),
    .m0_hbusreq    (m0_hbusreq),
    .m0_hgrant     (m0_hgrant),
    .m0_haddr      (m0_haddr),
    .m0_htrans     (m0_htrans),
    .m0_hwrite     (m0_hwrite),
    .m0_hsize      (m0_hsize),
    .m0_hburst     (m0_hburst),
    .m0_hprot      (m0_hprot),
    .m0_hwdata     (m0_hwdata),
    .m0_hready     (m0_hready),
    .m0_hresp      (m0_hresp),
    .m0_hrdata     (m0_hrdata),
    .m1_hbusreq    (m1_hbusreq),
    .m1_hgrant     (m1_hgrant),
    .m1_haddr      (m1_haddr),
    .m1_htrans     (m1_htrans),
    .m1_hwrite     (m1_hwrite),
    .m1_hsize      (m1_hsize),
    .m1_hburst     (m1_hburst),
    .m1_hprot      (m1_hprot),
    .m1_hwdata     (m1_hwdata),
    .m1_hready     (m1_hready),
    .m1_hresp      (m1_hresp),
    .m1_hrdata     (m1_hrdata),
    .sysahb_haddr  (sysahb_haddr),
    .sysahb_htrans (sysahb_htrans),
    .sysahb_hwrite (sysahb_hwrite),
    .sysahb_hsize  (sysahb_hsize),
    .sysahb_hburst (sysahb_hburst),
    .sysahb_hprot  (sysahb_hprot),
    .sysahb_hwdata (sysahb_hwdata),
    .sysahb_hready (sysahb_hready),
    .sysahb_hresp  (sysahb_hresp),
    .sysahb_hrdata (sysahb_hrdata)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow a further 1 ns later.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_hbusreq = 0; m0_haddr = '0; m0_htrans = 2'b00; m0_hwrite = 0;
    m0_hsize = 3'd2; m0_hburst = 3'd0; m0_hprot = 4'h3; m0_hwdata = '0;
    m1_hbusreq = 0; m1_haddr = '0; m1_htrans = 2'b00; m1_hwrite = 0;
    m1_hsize = 3'd0; m1_hburst = 3'd1; m1_hprot = 4'hC; m1_hwdata = '0;
    sysahb_hready = 1; sysahb_hresp = 0; sysahb_hrdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    sys_resetn = 0;
    step();
    step();
    sys_resetn = 1;
  endtask

  initial begin
    // ---- reset state, htrans forced IDLE while in reset ----
    idle_inputs();
    sys_resetn = 0;
    m0_htrans  = 2'b10;
    #2;
    chk("rst_m0_hgrant", 32'(m0_hgrant), 32'd1);
    chk("rst_m1_hgrant", 32'(m1_hgrant), 32'd0);
    chk("rst_htrans",    32'(sysahb_htrans), 32'd0);
    step();
    step();
    sys_resetn = 1;

    // ---- m0 NONSEQ read passes through unchanged ----
    m0_hbusreq = 1; m0_htrans = 2'b10; m0_haddr = 32'h2000_0010; m0_hwrite = 0;
    m0_hwdata = 32'h1111_1111;
    #1;
    chk("m0_haddr",  sysahb_haddr, 32'h2000_0010);
    chk("m0_htrans", 32'(sysahb_htrans), 32'd2);
    chk("m0_hprot",  32'(sysahb_hprot), 32'h3);
    step();

    // ---- m0 releases, m1 requests: grant moves one edge later ----
    m0_hbusreq = 0; m0_htrans = 2'b00; m1_hbusreq = 1;
    #1;
    chk("rel_pre_m1_hgrant", 32'(m1_hgrant), 32'd0);
    step();
    chk("rel_m1_hgrant", 32'(m1_hgrant), 32'd1);
    chk("rel_m0_hgrant", 32'(m0_hgrant), 32'd0);
    m1_htrans = 2'b10; m1_haddr = 32'h2000_0004; m1_hwrite = 1; m1_hwdata = 32'hA5A5_5A5A;
    #1;
    chk("m1_haddr",     sysahb_haddr, 32'h2000_0004);
    chk("m1_hwrite",    32'(sysahb_hwrite), 32'd1);
    chk("m1_hburst",    32'(sysahb_hburst), 32'd1);
    chk("m0_dphase_wd", sysahb_hwdata, 32'h1111_1111);
    step();
    m1_htrans = 2'b00;
    #1;
    chk("m1_hwdata", sysahb_hwdata, 32'hA5A5_5A5A);

    // ---- m0 INCR4 burst is not broken by an m1 request ----
    apply_reset();
    m0_hbusreq = 1; m0_hburst = 3'd3; m0_htrans = 2'b10; m0_haddr = 32'h0000_0100;
    step();
    m0_htrans = 2'b11; m0_haddr = 32'h0000_0104;
    m1_hbusreq = 1; m1_htrans = 2'b10; m1_haddr = 32'hDEAD_0000;
    #1;
    chk("burst_b2_grant", 32'(m0_hgrant), 32'd1);
    step();
    m0_haddr = 32'h0000_0108;
    #1;
    chk("burst_b3_grant", 32'(m0_hgrant), 32'd1);
    chk("burst_b3_haddr", sysahb_haddr, 32'h0000_0108);
    step();
    m0_haddr = 32'h0000_010C;
    #1;
    chk("burst_b4_grant", 32'(m0_hgrant), 32'd1);
    step();
    chk("burst_end_grant", 32'(m0_hgrant), 32'd1);
    m0_htrans = 2'b00; m0_hbusreq = 0;
    step();
    chk("burst_after_m1", 32'(m1_hgrant), 32'd1);

    // ---- hold limit 4: owner gets switched at the NONSEQ after 4 accepted ----
    apply_reset();
    m0_hbusreq = 1; m0_htrans = 2'b10;
    m1_hbusreq = 1; m1_htrans = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("hold_edge%0d", k), 32'(m1_hgrant),
          ((k >= 5 && k <= 9) ? 32'd1 : 32'd0));
    end

    // ---- wait states freeze grant and write-data owner ----
    apply_reset();
    m0_hbusreq = 1; m0_htrans = 2'b10; m0_hwrite = 1; m0_haddr = 32'h0000_0200;
    m0_hwdata = 32'hCAFE_0001; m1_hwdata = 32'hBAD0_0000; m1_hbusreq = 1;
    step();
    m0_htrans = 2'b00; m0_hbusreq = 0; sysahb_hready = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait%0d_grant", i), 32'(m0_hgrant), 32'd1);
      chk($sformatf("wait%0d_hwdata", i), sysahb_hwdata, 32'hCAFE_0001);
      step();
    end
    sysahb_hready = 1;
    #1;
    chk("wait_end_grant", 32'(m0_hgrant), 32'd1);
    step();
    chk("wait_switch_m1", 32'(m1_hgrant), 32'd1);

    // ---- two-cycle ERROR on an m1 data phase ----
    m1_htrans = 2'b10; m1_haddr = 32'h3000_0000; m1_hwrite = 0;
    step();
    m1_htrans = 2'b00; sysahb_hresp = 1; sysahb_hready = 0; sysahb_hrdata = 32'h1234_5678;
    #1;
    chk("err1_m1_hresp", 32'(m1_hresp), 32'd1);
    chk("err1_m0_hresp", 32'(m0_hresp), 32'd0);
    chk("m0_hready_bc",  32'(m0_hready), 32'd0);
    chk("m0_hrdata_bc",  m0_hrdata, 32'h1234_5678);
    chk("m1_hrdata_bc",  m1_hrdata, 32'h1234_5678);
    step();
    sysahb_hready = 1;
    #1;
    chk("err2_m1_hresp", 32'(m1_hresp), 32'd1);
    chk("err2_m0_hresp", 32'(m0_hresp), 32'd0);
    chk("err2_grant",    32'(m1_hgrant), 32'd1);

    // ---- asynchronous reset in the middle of an m1 burst ----
    sysahb_hresp = 0;
    m1_htrans = 2'b10; m1_hburst = 3'd3; m1_haddr = 32'h0000_0040;
    step();
    m1_htrans = 2'b11; m1_haddr = 32'h0000_0044;
    step();
    m0_htrans = 2'b10;
    #1;
    chk("midburst_htrans", 32'(sysahb_htrans), 32'd3);
    sys_resetn = 0;
    #1;
    chk("arst_m0_hgrant", 32'(m0_hgrant), 32'd1);
    chk("arst_m1_hgrant", 32'(m1_hgrant), 32'd0);
    chk("arst_htrans",    32'(sysahb_htrans), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
